// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_HOLD_CYCLES     = 32'd1024;
  localparam int unsigned DEF_STAGGER_CYCLES  = 32'd16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd65536;

  // Larger of two counts; sizes the shared phase counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous control bit.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture the asynchronous input and give the first stage a cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/reset_sequencer_chk.sv
// Invariant checker for the reset sequencer outputs and phase counter.
module reset_sequencer_chk #(
  parameter int unsigned CW       = 32'd4,
  parameter int unsigned CNT_TERM = 32'd7
) (
  input logic          clk,
  input logic          reset,
  input logic          periph_rst,
  input logic          cpu_rst,
  input logic          ready,
  input logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] TERM_C = CW'(CNT_TERM);

  a_cpu_implies_periph: assert property (@(posedge clk) disable iff (reset)
    (!cpu_rst) |-> (!periph_rst));

  a_ready_is_not_cpu_rst: assert property (@(posedge clk) disable iff (reset)
    ready == !cpu_rst);

  a_cnt_bounded: assert property (@(posedge clk) disable iff (reset)
    cnt <= TERM_C);

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for PLL lock, holds peripherals in reset for
// HOLD_CYCLES of stable lock, then releases the CPU STAGGER_CYCLES later.
// Optional feature macro: RESET_SEQ_BTN_DEBOUNCE_EN -- when defined, a
// debounced press of btn restarts the sequence just like a lock loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic lock,
  input  logic btn,
  output logic periph_rst,
  output logic cpu_rst,
  output logic ready
);

  localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX) + 32'd1;

  localparam logic [CW-1:0] HOLD_TERM    = CW'(HOLD_CYCLES - 32'd1);
  localparam logic [CW-1:0] STAGGER_TERM = CW'(STAGGER_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);

  seq_state_e    state_r;
  seq_state_e    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          periph_rst_r;
  logic          cpu_rst_r;
  logic          ready_r;
  logic          periph_nxt_s;
  logic          cpu_nxt_s;
  logic          ready_nxt_s;
  logic          lock_s;
  logic          press_s;
  logic          abort_s;

  bit_sync u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lock),
    .q     (lock_s)
  );

`ifdef RESET_SEQ_BTN_DEBOUNCE_EN
  localparam int unsigned   DW       = $clog2(DEBOUNCE_CYCLES) + 32'd1;
  localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DW-1:0] DEB_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DEB_ONE  = DW'(1'b1);

  logic          btn_s;
  logic [DW-1:0] deb_cnt_r;
  logic          fired_r;

  bit_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );

  // A press is the DEBOUNCE_CYCLES-th consecutive high sample; fired_r keeps
  // a long press from restarting the sequence more than once.
  assign press_s = btn_s && (deb_cnt_r == DEB_TERM) && !fired_r;

  // Count consecutive high button samples; any low sample re-arms the press.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_r <= DEB_ZERO;
      fired_r   <= 1'b0;
    end else if (!btn_s) begin
      deb_cnt_r <= DEB_ZERO;
      fired_r   <= 1'b0;
    end else begin
      if (deb_cnt_r != DEB_TERM) begin
        deb_cnt_r <= deb_cnt_r + DEB_ONE;
      end
      if (press_s) begin
        fired_r <= 1'b1;
      end
    end
  end
`else
  logic unused_btn_s;
  assign unused_btn_s = btn;
  assign press_s      = 1'b0;
`endif

  // Lock loss and a button press abort the sequence with the same priority.
  assign abort_s = !lock_s || press_s;

  // Next-state and counter logic; abort always wins over terminal count.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        cnt_nxt_s = CNT_ZERO;
        if (lock_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      HOLD: begin
        if (abort_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == HOLD_TERM) begin
          state_nxt_s = STAGGER;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      STAGGER: begin
        if (abort_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == STAGGER_TERM) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = STAGGER;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        cnt_nxt_s = CNT_ZERO;
        if (abort_s) begin
          state_nxt_s = WAIT_LOCK;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and remain glitch-free flops.
  assign periph_nxt_s = (state_nxt_s == WAIT_LOCK) || (state_nxt_s == HOLD);
  assign cpu_nxt_s    = (state_nxt_s != RUN);
  assign ready_nxt_s  = (state_nxt_s == RUN);

  // State, counter and registered reset outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= WAIT_LOCK;
      cnt_r        <= CNT_ZERO;
      periph_rst_r <= 1'b1;
      cpu_rst_r    <= 1'b1;
      ready_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      periph_rst_r <= periph_nxt_s;
      cpu_rst_r    <= cpu_nxt_s;
      ready_r      <= ready_nxt_s;
    end
  end

  assign periph_rst = periph_rst_r;
  assign cpu_rst    = cpu_rst_r;
  assign ready      = ready_r;

  reset_sequencer_chk #(
    .CW       (CW),
    .CNT_TERM (CNT_MAX - 32'd1)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .periph_rst (periph_rst_r),
    .cpu_rst    (cpu_rst_r),
    .ready      (ready_r),
    .cnt        (cnt_r)
  );

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (HOLD=8, STAGGER=4, DEBOUNCE=5).
// Edge E0 is the first rising edge that samples lock high after a clean reset.
// Expected {periph_rst, cpu_rst, ready} per edge are queued up front and
// popped one per edge, sampled 1 ns after the rising edge.
module tb_reset_sequencer;

  localparam logic [2:0] O_WAIT = 3'b110;
  localparam logic [2:0] O_STAG = 3'b010;
  localparam logic [2:0] O_RUN  = 3'b001;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic lock  = 1'b0;
  logic btn   = 1'b0;
  logic periph_rst;
  logic cpu_rst;
  logic ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] sb_q[$];
  logic [2:0] exp_v;

  reset_sequencer #(
    .HOLD_CYCLES     (8),
    .STAGGER_CYCLES  (4),
    .DEBOUNCE_CYCLES (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lock       (lock),
    .btn        (btn),
    .periph_rst (periph_rst),
    .cpu_rst    (cpu_rst),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push_range(input int from, input int to, input logic [2:0] v);
    for (int e = from; e <= to; e++) sb_q.push_back(v);
  endtask

  // Clean start: reset with lock low, then release reset with lock still low.
  task automatic prep();
    @(negedge clk);
    reset = 1'b1; lock = 1'b0; btn = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    prep();
    push_range(0, 3, O_WAIT);
    for (int e = 0; e < 4; e++) begin
      @(negedge clk); reset = 1'b1; lock = 1'b1;
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL reset e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_power_on();
    prep();
    push_range(0, 9, O_WAIT); push_range(10, 13, O_STAG); push_range(14, 19, O_RUN);
    for (int e = 0; e < 20; e++) begin
      @(negedge clk); lock = 1'b1;
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL power_on e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
  endtask

  task automatic test_hold_glitch();
    prep();
    push_range(0, 16, O_WAIT); push_range(17, 20, O_STAG); push_range(21, 24, O_RUN);
    for (int e = 0; e < 25; e++) begin
      @(negedge clk); lock = (e != 6);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL hold_glitch e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
  endtask

  // Lock loss seen in the very cycle the hold counter hits terminal count.
  task automatic test_priority();
    prep();
    push_range(0, 18, O_WAIT); push_range(19, 22, O_STAG); push_range(23, 26, O_RUN);
    for (int e = 0; e < 27; e++) begin
      @(negedge clk); lock = (e != 8);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL priority e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
  endtask

  task automatic test_run_drop();
    prep();
    push_range(0, 9, O_WAIT);   push_range(10, 13, O_STAG); push_range(14, 21, O_RUN);
    push_range(22, 34, O_WAIT); push_range(35, 38, O_STAG); push_range(39, 42, O_RUN);
    for (int e = 0; e < 43; e++) begin
      @(negedge clk); lock = !(e >= 20 && e <= 24);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL run_drop e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
  endtask

  task automatic test_reset_stagger();
    prep();
    push_range(0, 9, O_WAIT);   push_range(10, 11, O_STAG);
    push_range(12, 22, O_WAIT); push_range(23, 26, O_STAG); push_range(27, 30, O_RUN);
    for (int e = 0; e < 31; e++) begin
      @(negedge clk); lock = 1'b1; reset = (e == 12);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_stagger e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  // Short press (4 samples) then a long press (10 samples) while in RUN.
  task automatic test_btn();
    prep();
    push_range(0, 9, O_WAIT); push_range(10, 13, O_STAG);
`ifdef RESET_SEQ_BTN_DEBOUNCE_EN
    push_range(14, 35, O_RUN);
    push_range(36, 44, O_WAIT); push_range(45, 48, O_STAG); push_range(49, 52, O_RUN);
`else
    push_range(14, 52, O_RUN);
`endif
    for (int e = 0; e < 53; e++) begin
      @(negedge clk); lock = 1'b1;
      btn = (e >= 20 && e <= 23) || (e >= 30 && e <= 39);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front(); tests_run++;
      if ({periph_rst, cpu_rst, ready} !== exp_v) begin
        tests_failed++;
        $display("FAIL btn e=%0d got=%b exp=%b", e, {periph_rst, cpu_rst, ready}, exp_v);
      end
    end
    @(negedge clk); btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_hold_glitch();
    test_priority();
    test_run_drop();
    test_reset_stagger();
    test_btn();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024: cycles of stable lock before periph_rst release (min 1).
REQ-002 SHALL have parameter STAGGER_CYCLES, default 16: cycles between periph_rst and cpu_rst release (min 1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536: cycles btn must stay high to count as a press (min 1).
REQ-004 SHALL have port clk, input, 1 bit: PLL output clock; the only clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port lock, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-007 SHALL have port btn, input, 1 bit: external reset button, active-high, asynchronous.
REQ-008 SHALL have port periph_rst, output, 1 bit: active-high reset for peripherals.
REQ-009 SHALL have port cpu_rst, output, 1 bit: active-high reset for the RISC-V core.
REQ-010 SHALL have port ready, output, 1 bit: high only in RUN.

Function
REQ-011 SHALL synchronise lock through two flops (lock_s) before any use.
REQ-012 SHALL implement states WAIT_LOCK, HOLD, STAGGER, RUN, with all outputs registered.
REQ-013 WAIT_LOCK: periph_rst=1, cpu_rst=1, ready=0; lock_s=1 -> HOLD with cnt=0.
REQ-014 HOLD: cnt increments each cycle; lock_s=0 -> WAIT_LOCK; cnt==HOLD_CYCLES-1 -> STAGGER, cnt=0, periph_rst=0 at the same edge.
REQ-015 STAGGER: cnt increments; lock_s=0 -> WAIT_LOCK with periph_rst=1; cnt==STAGGER_CYCLES-1 -> RUN, cpu_rst=0, ready=1 at the same edge.
REQ-016 RUN: lock_s=0 -> WAIT_LOCK, with periph_rst=1, cpu_rst=1 and ready=0 at the next edge.
REQ-017 Timing: lock rising before edge E0 -> periph_rst falls at E(HOLD_CYCLES+2) -> cpu_rst falls STAGGER_CYCLES edges later.
REQ-018 Lock loss SHALL take priority over counter terminal count in the same cycle.
REQ-019 cnt width SHALL be $clog2(max(HOLD_CYCLES,STAGGER_CYCLES))+1; cnt SHALL never wrap.
REQ-020 Invariant: cpu_rst=0 implies periph_rst=0; ready == !cpu_rst.

Reset
REQ-021 reset=1 at an edge SHALL force WAIT_LOCK, cnt=0, sync flops=0, periph_rst=1, cpu_rst=1, ready=0, from any state.
REQ-022 Reset mid-HOLD/STAGGER/RUN SHALL restart the full sequence; no partial credit for elapsed cycles.

Configuration
REQ-023 With macro RESET_SEQ_BTN_DEBOUNCE_EN defined, btn SHALL be two-flop synchronised and debounced.
REQ-024 With RESET_SEQ_BTN_DEBOUNCE_EN defined: btn_s high for DEBOUNCE_CYCLES consecutive cycles SHALL force WAIT_LOCK exactly like lock loss; any low sample clears the debounce counter; the event fires once per press.
REQ-025 Without RESET_SEQ_BTN_DEBOUNCE_EN: btn SHALL be ignored, the debounce counter SHALL be absent, and the port SHALL remain present.

Structure
REQ-026 Package reset_seq_pkg SHALL hold the state enum (WAIT_LOCK, HOLD, STAGGER, RUN) and default parameter constants.
REQ-027 The two-flop synchroniser SHALL be sub-module bit_sync, instantiated for lock and for btn when enabled.
REQ-028 Target size: 120-400 lines RTL; no vendor primitives.

Verification (bench HOLD_CYCLES=8, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=5)
REQ-029 Lock high from cycle 0 -> periph_rst falls at edge 10, cpu_rst and ready change at edge 14.
REQ-030 Lock drops for 1 cycle at edge 6 (in HOLD) -> WAIT_LOCK; periph_rst stays 1; the count restarts and release occurs 8 cycles after re-entering HOLD.
REQ-031 Lock drops in RUN -> periph_rst=1, cpu_rst=1, ready=0 at 3 edges after the drop; full sequence repeats on relock.
REQ-032 reset pulsed at edge 12 (STAGGER) -> all outputs are reset values at edge 13; with lock held high, periph_rst falls at edge 23.
REQ-033 Macro defined, btn high for 4 cycles -> no effect; btn high for 5 or more synced cycles in RUN -> WAIT_LOCK once; macro undefined -> btn toggling has no effect.
REQ-034 Assertions every cycle: REQ-020 invariants; cnt never exceeds its terminal value.
